// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier / accumulator slice.
package mult_pkg;

  localparam int TAM_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACUM = 2'd1,
    HOLD = 2'd2
  } acum_state_t;

  // Width needed to count from 0 up to n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/acum_mult_det_flanco.sv
// det_flanco: rising-edge detector. The history flop resets to RST_VAL so a
// level already high when reset is released can be masked (RST_VAL=1).
module det_flanco #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_rise
);

  logic r_d_q;

  // Previous-cycle copy of the input level.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_d_q <= RST_VAL;
    else       r_d_q <= i_d;
  end

  assign o_rise = i_d & ~r_d_q;

endmodule

// File: rtl/acum_mult.sv
// acum_mult: sums N_TERMS consecutive products from the multiplier and offers
// the total on a valid/ready port.
// Optional build macro: ACUM_SATURATION_EN (clamp on overflow instead of wrap).
//
// state | meaning
// IDLE  | no product captured in the current batch
// ACUM  | 1..N_TERMS-1 products summed, waiting for more
// HOLD  | batch complete, DOUT/DOUT_VALID presented until DOUT_READY
module acum_mult
  import mult_pkg::*;
#(
  parameter int TAM     = TAM_DEF,
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 2*TAM + 4
) (
  input  logic                        CLOCK,
  input  logic                        RESET,
  input  logic                        END_MULT,
  input  logic [2*TAM-1:0]            S,
  input  logic                        CLEAR,
  output logic [ACC_W-1:0]            DOUT,
  output logic                        DOUT_VALID,
  input  logic                        DOUT_READY,
  output logic [cnt_w(N_TERMS)-1:0]   COUNT,
  output logic                        BUSY,
  output logic                        OVF,
  output logic                        LOST
);

  localparam int CW = cnt_w(N_TERMS);
  localparam logic [CW-1:0] LAST_CNT = CW'(N_TERMS);
  localparam acum_state_t FIRST_ST = (N_TERMS == 1) ? HOLD : ACUM;

  acum_state_t     r_state, w_state_nxt;
  logic [ACC_W-1:0] r_acc, w_acc_nxt;
  logic [CW-1:0]   r_count, w_cnt_nxt;
  logic            r_valid, r_busy, r_ovf, r_lost;
  logic            w_ovf_nxt, w_lost_nxt;
  logic            w_cap, w_hs;
  logic [ACC_W-1:0] w_s_ext;
  logic [ACC_W:0]  w_sum;

  det_flanco #(.RST_VAL(1'b1)) u_det_end (
    .i_clk  (CLOCK),
    .i_rst  (RESET),
    .i_d    (END_MULT),
    .o_rise (w_cap)
  );

  assign w_s_ext = ACC_W'(S);
  assign w_sum   = {1'b0, r_acc} + {1'b0, w_s_ext};
  assign w_hs    = r_valid & DOUT_READY;

  // Next-state and datapath decisions; CLEAR overrides capture and handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_count;
    w_ovf_nxt   = r_ovf;
    w_lost_nxt  = r_lost;
    if (CLEAR) begin
      w_state_nxt = IDLE;
      w_acc_nxt   = '0;
      w_cnt_nxt   = '0;
      w_ovf_nxt   = 1'b0;
      w_lost_nxt  = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_cap) begin
            w_acc_nxt   = w_s_ext;
            w_cnt_nxt   = CW'(1);
            w_state_nxt = FIRST_ST;
          end
        end
        ACUM: begin
          if (w_cap) begin
            if (w_sum[ACC_W]) begin
              w_ovf_nxt = 1'b1;
`ifdef ACUM_SATURATION_EN
              w_acc_nxt = '1;
`else
              w_acc_nxt = w_sum[ACC_W-1:0];
`endif
            end else begin
              w_acc_nxt = w_sum[ACC_W-1:0];
            end
            w_cnt_nxt = r_count + CW'(1);
            if (r_count == LAST_CNT - CW'(1)) w_state_nxt = HOLD;
          end
        end
        HOLD: begin
          if (w_hs) begin
            // A product arriving with the handshake opens the next batch.
            w_ovf_nxt = 1'b0;
            if (w_cap) begin
              w_acc_nxt   = w_s_ext;
              w_cnt_nxt   = CW'(1);
              w_state_nxt = FIRST_ST;
            end else begin
              w_acc_nxt   = '0;
              w_cnt_nxt   = '0;
              w_state_nxt = IDLE;
            end
          end else if (w_cap) begin
            w_lost_nxt = 1'b1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State and output registers; flags are derived from the next state so
  // every output comes straight from a flop.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_ovf   <= 1'b0;
      r_lost  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_count <= w_cnt_nxt;
      r_valid <= (w_state_nxt == HOLD);
      r_busy  <= (w_state_nxt != IDLE);
      r_ovf   <= w_ovf_nxt;
      r_lost  <= w_lost_nxt;
    end
  end

  assign DOUT       = r_acc;
  assign DOUT_VALID = r_valid;
  assign COUNT      = r_count;
  assign BUSY       = r_busy;
  assign OVF        = r_ovf;
  assign LOST       = r_lost;

endmodule

// File: tb/tb_acum_mult.sv
// Bench for acum_mult: instance A (N_TERMS=4) and C (N_TERMS=1) share stimulus
// and are checked every cycle against a batch-level model; instance B
// (TAM=8, ACC_W=16) exercises overflow with literal expectations.
module tb_acum_mult;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic        END_MULT = 1'b0;
  logic [31:0] S = '0;
  logic        CLEAR = 1'b0;
  logic        DOUT_READY = 1'b1;

  logic [35:0] a_dout, c_dout;
  logic        a_valid, c_valid, a_busy, c_busy, a_ovf, c_ovf, a_lost, c_lost;
  logic [2:0]  a_cnt;
  logic [0:0]  c_cnt;

  logic        b_end = 1'b0;
  logic [15:0] b_s = '0;
  logic        b_clear = 1'b0;
  logic        b_ready = 1'b1;
  logic [15:0] b_dout;
  logic        b_valid, b_busy, b_ovf, b_lost;
  logic [2:0]  b_cnt;

  int checks = 0;
  int errors = 0;
  bit run_chk = 1'b0;

  acum_mult #(.TAM(16), .N_TERMS(4), .ACC_W(36)) dut_a (
    .CLOCK(CLOCK), .RESET(RESET), .END_MULT(END_MULT), .S(S), .CLEAR(CLEAR),
    .DOUT(a_dout), .DOUT_VALID(a_valid), .DOUT_READY(DOUT_READY), .COUNT(a_cnt),
    .BUSY(a_busy), .OVF(a_ovf), .LOST(a_lost)
  );

  acum_mult #(.TAM(16), .N_TERMS(1), .ACC_W(36)) dut_c (
    .CLOCK(CLOCK), .RESET(RESET), .END_MULT(END_MULT), .S(S), .CLEAR(CLEAR),
    .DOUT(c_dout), .DOUT_VALID(c_valid), .DOUT_READY(DOUT_READY), .COUNT(c_cnt),
    .BUSY(c_busy), .OVF(c_ovf), .LOST(c_lost)
  );

  acum_mult #(.TAM(8), .N_TERMS(4), .ACC_W(16)) dut_b (
    .CLOCK(CLOCK), .RESET(RESET), .END_MULT(b_end), .S(b_s), .CLEAR(b_clear),
    .DOUT(b_dout), .DOUT_VALID(b_valid), .DOUT_READY(b_ready), .COUNT(b_cnt),
    .BUSY(b_busy), .OVF(b_ovf), .LOST(b_lost)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // ---------------- batch-level model for A (k=0) and C (k=1) ----------------
  localparam longint MOD = 64'd1 << 36;
  longint m_acc  [2];
  int     m_cnt  [2];
  bit     m_valid[2], m_ovf[2], m_lost[2], m_prev[2];
  bit     m_cap, m_hs;
  int     m_nt;

  always @(posedge CLOCK or posedge RESET) begin
    for (int k = 0; k < 2; k++) begin
      m_nt = (k == 0) ? 4 : 1;
      if (RESET) begin
        m_acc[k] = 0; m_cnt[k] = 0; m_valid[k] = 0;
        m_ovf[k] = 0; m_lost[k] = 0; m_prev[k] = 1;
      end else begin
        m_cap = END_MULT && !m_prev[k];
        m_prev[k] = END_MULT;
        m_hs = m_valid[k] && DOUT_READY;
        if (CLEAR) begin
          m_acc[k] = 0; m_cnt[k] = 0; m_valid[k] = 0; m_ovf[k] = 0; m_lost[k] = 0;
        end else if (m_valid[k]) begin
          if (m_hs) begin
            m_ovf[k] = 0;
            if (m_cap) begin
              m_acc[k] = longint'(S); m_cnt[k] = 1; m_valid[k] = (m_nt == 1);
            end else begin
              m_acc[k] = 0; m_cnt[k] = 0; m_valid[k] = 0;
            end
          end else if (m_cap) begin
            m_lost[k] = 1;
          end
        end else if (m_cap) begin
          if (m_cnt[k] == 0) m_acc[k] = longint'(S);
          else begin
            m_acc[k] = m_acc[k] + longint'(S);
            if (m_acc[k] >= MOD) begin
              m_ovf[k] = 1;
`ifdef ACUM_SATURATION_EN
              m_acc[k] = MOD - 1;
`else
              m_acc[k] = m_acc[k] - MOD;
`endif
            end
          end
          m_cnt[k]   = m_cnt[k] + 1;
          m_valid[k] = (m_cnt[k] == m_nt);
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge CLOCK) begin
    if (run_chk) begin
      cmp("a_valid", a_valid, m_valid[0]);
      cmp("a_count", a_cnt, m_cnt[0]);
      cmp("a_busy",  a_busy, m_valid[0] || m_cnt[0] > 0);
      cmp("a_ovf",   a_ovf, m_ovf[0]);
      cmp("a_lost",  a_lost, m_lost[0]);
      if (m_valid[0]) cmp("a_dout", a_dout, m_acc[0]);
      cmp("c_valid", c_valid, m_valid[1]);
      cmp("c_count", c_cnt, m_cnt[1]);
      cmp("c_busy",  c_busy, m_valid[1] || m_cnt[1] > 0);
      cmp("c_lost",  c_lost, m_lost[1]);
      if (m_valid[1]) cmp("c_dout", c_dout, m_acc[1]);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic pulse(input logic [31:0] v);
    END_MULT = 1'b1; S = v; tick();
  endtask

  task automatic rel();
    END_MULT = 1'b0; tick();
  endtask

  task automatic pulse_b(input logic [15:0] v);
    b_end = 1'b1; b_s = v; tick();
    b_end = 1'b0; tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    run_chk = 1'b1;
    cmp("rst_dout",  a_dout, 0);
    cmp("rst_count", a_cnt, 0);
    cmp("rst_busy",  a_busy, 0);
    RESET = 1'b0;
    tick();

    // Basic sum: 15 + 120 + 225 + 510 = 870
    pulse(15);  cmp("t1_cnt1", a_cnt, 1); rel();
    pulse(120); cmp("t1_cnt2", a_cnt, 2); rel();
    pulse(225); cmp("t1_cnt3", a_cnt, 3); rel();
    pulse(510);
    cmp("t1_valid", a_valid, 1);
    cmp("t1_dout",  a_dout, 870);
    cmp("t1_cnt4",  a_cnt, 4);
    rel();
    cmp("t1_valid_one_cycle", a_valid, 0);
    cmp("t1_cnt0", a_cnt, 0);

    // Long END_MULT: one capture only
    DOUT_READY = 1'b0;
    END_MULT = 1'b1; S = 30000;
    for (int i = 0; i < 3; i++) begin
      tick();
      cmp("t2_cnt", a_cnt, 1);
    end
    rel();

    // Backpressure: complete batch, hold, late product dropped
    pulse(100); rel();
    pulse(200); rel();
    pulse(300);
    cmp("t3_valid", a_valid, 1);
    for (int i = 0; i < 5; i++) begin
      rel();
      cmp("t3_dout_stable", a_dout, 30600);
    end
    pulse(256);
    cmp("t3_lost", a_lost, 1);
    cmp("t3_dout_kept", a_dout, 30600);
    rel();
    DOUT_READY = 1'b1;
    tick();
    cmp("t3_idle_busy", a_busy, 0);
    cmp("t3_lost_sticky", a_lost, 1);

    // Handshake and capture in the same cycle
    DOUT_READY = 1'b0;
    pulse(1); rel(); pulse(2); rel(); pulse(3); rel(); pulse(4); rel();
    cmp("t4_valid", a_valid, 1);
    cmp("t4_dout", a_dout, 10);
    DOUT_READY = 1'b1;
    pulse(300);
    cmp("t4_cnt1", a_cnt, 1);
    cmp("t4_valid_drop", a_valid, 0);
    cmp("t4_c_dout", c_dout, 300);
    rel();
    pulse(5); rel(); pulse(6); rel(); pulse(7);
    cmp("t4_dout_next", a_dout, 318);
    rel();

    // Overflow on the narrow instance
    pulse_b(16'd65025);
    cmp("t5_ovf_first", b_ovf, 0);
    pulse_b(16'd65025);
    cmp("t5_ovf_second", b_ovf, 1);
    pulse_b(16'd65025);
    b_end = 1'b1; b_s = 16'd65025; tick();
    cmp("t5_valid", b_valid, 1);
    cmp("t5_ovf", b_ovf, 1);
`ifdef ACUM_SATURATION_EN
    cmp("t5_dout", b_dout, 65535);
`else
    cmp("t5_dout", b_dout, 63492);
`endif
    b_end = 1'b0; tick();
    cmp("t5_ovf_cleared", b_ovf, 0);

    // Abort with CLEAR (capture in the CLEAR cycle ignored)
    pulse(7); rel(); pulse(8); rel();
    cmp("t6_cnt2", a_cnt, 2);
    CLEAR = 1'b1; END_MULT = 1'b1; S = 999; tick();
    CLEAR = 1'b0;
    cmp("t6_clr_cnt", a_cnt, 0);
    cmp("t6_clr_busy", a_busy, 0);
    cmp("t6_clr_lost", a_lost, 0);
    tick();
    cmp("t6_no_cap_after_clr", a_cnt, 0);
    rel();

    // Reset mid-batch with END_MULT high through release
    pulse(9);
    cmp("t6_pre_rst", a_cnt, 1);
    RESET = 1'b1;
    #1;
    cmp("t6_async_cnt", a_cnt, 0);
    tick();
    RESET = 1'b0;
    tick(); tick();
    cmp("t6_rst_cnt", a_cnt, 0);
    cmp("t6_rst_busy", a_busy, 0);
    cmp("t6_rst_dout", a_dout, 0);
    cmp("t6_rst_valid", a_valid, 0);
    rel();
    pulse(11);
    cmp("t6_cap_after", a_cnt, 1);
    rel();
    tick();

    run_chk = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/acum_mult.md
# acum_mult

Result accumulator sitting directly downstream of the `multipli` sequential multiplier. It consumes each finished product `S` on the rising edge of `END_MULT` and sums `N_TERMS` consecutive products into one wide result. It then presents the sum on a valid/ready output port. Typical use is dot-product / MAC chains where the multiplier is restarted once per operand pair.

## Interface
- `TAM`, 16: operand width of the upstream multiplier; product width is 2*TAM.
- `N_TERMS`, 4: products summed per result; legal range ≥ 1.
- `ACC_W`, 2*TAM+4: accumulator and result width; legal range ≥ 2*TAM.

Ports:
- `CLOCK`  in  1: single system clock, rising edge.
- `RESET`  in  1: asynchronous, active-high reset.
- `END_MULT`  in  1: multiplier done level; may stay high ≥1 cycle.
- `S`  in  2*TAM: product, stable while `END_MULT`=1.
- `CLEAR`  in  1: synchronous abort/restart of the current batch.
- `DOUT`  out  ACC_W: accumulated sum; meaningful only while `DOUT_VALID`=1.
- `DOUT_VALID`  out  1: result available.
- `DOUT_READY`  in  1: consumer accepts the result.
- `COUNT`  out  $clog2(N_TERMS+1): products captured in the current batch.
- `BUSY`  out  1: high whenever state ≠ IDLE.
- `OVF`  out  1: sticky; accumulator overflowed in the current batch.
- `LOST`  out  1: sticky; a product arrived while in HOLD and was dropped.

## Operation
- **Edge detection:** `end_q` registers `END_MULT`; `cap = END_MULT & ~end_q`. Exactly one capture happens per multiplication, however long `END_MULT` stays high.
- **FSM states:** IDLE, ACUM, HOLD.
  - IDLE + cap: `acc ← zext(S)`, `COUNT ← 1`. Go to ACUM, or go to HOLD if N_TERMS=1.
  - ACUM + cap: `acc ← acc + zext(S)`, `COUNT` increments. Go to HOLD when `COUNT` reaches N_TERMS.
  - HOLD: `DOUT_VALID`=1 and `DOUT`=acc, both held stable until `DOUT_READY`=1.
    - Handshake (`DOUT_VALID & DOUT_READY`) without cap: `acc ← 0`, `COUNT ← 0`, clear `OVF`, go to IDLE.
    - Handshake and cap in the same cycle: the product starts the next batch. `acc ← zext(S)`, `COUNT ← 1`, go to ACUM (or stay in HOLD if N_TERMS=1). Nothing is lost.
    - Cap without handshake: the product is dropped and `LOST ← 1`.
- **Arithmetic:** unsigned addition, width ACC_W. On a carry out of ACC_W bits, `OVF ← 1`; behaviour is then per the Configuration section.
- **CLEAR priority:** CLEAR has priority over capture and handshake. It forces IDLE, `acc=0`, `COUNT=0`, `OVF=0`, `LOST=0`, `DOUT_VALID=0`, and discards any pending result. A cap in the CLEAR cycle is ignored.
- **Reset mid-batch:** behaves like CLEAR, but asynchronously.

## Timing
- **Reset values:**
  - `DOUT`=0, `DOUT_VALID`=0, `COUNT`=0, `BUSY`=0, `OVF`=0, `LOST`=0, state=IDLE.
  - `end_q` resets to 1, so `END_MULT` already high at reset release is not captured.
- **Capture:** `S` is sampled at the first rising `CLOCK` where `END_MULT`=1 and `end_q`=0.
- **Result latency:** `DOUT_VALID` rises on the same clock edge that captures the N_TERMS-th product, i.e. 1 cycle after that capture cycle begins. There is no extra pipeline stage.
- **Throughput:** one capture per cycle is accepted; upstream `multipli` limits the real rate.
- **Output registers:** `DOUT`, `DOUT_VALID`, `COUNT`, `BUSY`, `OVF` and `LOST` are all registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `ACUM_SATURATION_EN`.
- Defined: on overflow the accumulator clamps to 2^ACC_W−1 and stays there for the rest of the batch; `OVF`=1.
- Undefined: the accumulator wraps modulo 2^ACC_W; `OVF`=1.

## Structure
- Package `mult_pkg`:
  - `TAM_DEF` (16);
  - `acum_state_t` enum {IDLE, ACUM, HOLD};
  - helper function `cnt_w(n)` = $clog2(n+1).
- Sub-module `det_flanco`: rising-edge detector with a reset value parameter, instantiated once for `END_MULT`.

## Test plan
1. **Basic sum.** TAM=16, N_TERMS=4. Products 15, 120, 225, 510 (3·5, 10·12, 15·15, 255·2), `DOUT_READY`=1 → `DOUT`=870, `DOUT_VALID` high exactly 1 cycle, `COUNT` 1→2→3→4→0.
2. **Long END_MULT.** `END_MULT` held high 3 cycles with `S`=30000 → exactly one capture, `COUNT`=1.
3. **Backpressure.** `DOUT_READY`=0 for 5 cycles after valid, then one extra product 256 arrives → `DOUT` is stable at the old sum, `LOST`=1. When ready rises, IDLE, `LOST` still 1.
4. **Simultaneous handshake + cap.** Cap of `S`=300 in the handshake cycle → next batch starts with `COUNT`=1, `acc`=300.
5. **Overflow.** TAM=8, ACC_W=16, four products 65025 (255·255) → `OVF`=1. `DOUT`=63492 without `ACUM_SATURATION_EN`; `DOUT`=65535 with it.
6. **Abort.** CLEAR asserted after 2 products → IDLE, `COUNT`=0. `RESET` asserted with `END_MULT` high then released → no capture, all outputs 0.
